mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles from mem_en cycle to mem_rdata valid; legal range 1..15.
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk input 1, sole clock, rising edge.
REQ-005 SHALL have port reset input 1, asynchronous active-high reset.
REQ-006 SHALL have ports rN_req input 1, requester N (N=0 core, N=1 loader/DMA) requests one access; level.
REQ-007 SHALL have ports rN_we input 1, write when 1, read when 0.
REQ-008 SHALL have ports rN_be input 4, byte enables for writes.
REQ-009 SHALL have ports rN_addr input AW, byte address.
REQ-010 SHALL have ports rN_wdata input 32, write data.
REQ-011 SHALL have ports rN_gnt output 1, high while requester N owns the memory.
REQ-012 SHALL have ports rN_done output 1, one-cycle completion pulse.
REQ-013 SHALL have ports rN_rdata output 32, read data, valid when rN_done=1 on a read.
REQ-014 SHALL have ports mem_en, mem_we output 1; mem_be output 4; mem_addr output AW; mem_wdata output 32; all to the shared unified memory.
REQ-015 SHALL have port mem_rdata input 32, memory read data.
REQ-016 SHALL have port busy output 1, high when state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-018 In IDLE with any rN_req=1, SHALL select an owner, latch its we/be/addr/wdata, and go to ISSUE at the next edge; with no request, SHALL stay in IDLE.
REQ-019 On simultaneous r0_req and r1_req in IDLE, SHALL grant the requester not granted last (round-robin); last-owner resets to 1, so r0 wins the first tie.
REQ-020 With a single request, SHALL grant that requester regardless of last-owner.
REQ-021 ISSUE SHALL last exactly one cycle, with mem_en=1, mem_we=latched we, and mem_addr/mem_be/mem_wdata driven from latched registers, never from live requester inputs.
REQ-022 Outside ISSUE, SHALL hold mem_en=0 and mem_we=0.
REQ-023 On leaving ISSUE, SHALL load a 4-bit counter with MEM_LAT-1 and enter WAIT.
REQ-024 WAIT SHALL decrement the counter each cycle; at the edge where the counter is 0, SHALL capture mem_rdata into owner's rN_rdata and enter RESP.
REQ-025 RESP SHALL last one cycle, with owner's rN_done=1; SHALL NOT arbitrate in RESP; next state IDLE; last-owner updated to current owner.
REQ-026 Writes SHALL follow the same timing as reads; rN_rdata on a write is don't-care but SHALL retain its previous value.
REQ-027 Latency: request seen in IDLE at cycle 0 -> ISSUE cycle 1 -> done in cycle 2+MEM_LAT; back-to-back period 3+MEM_LAT cycles.
REQ-028 rN_gnt SHALL be high from ISSUE through RESP for the owner only; never both high.
REQ-029 rN_rdata of the non-owner SHALL be unchanged.
REQ-030 Deassertion of rN_req after ISSUE SHALL NOT abort the transaction; done still pulses.
REQ-031 req still high in the cycle after RESP SHALL be treated as a new transaction.
REQ-032 A requester SHALL hold req and fields stable until it is granted; the arbiter samples them only in IDLE.

Reset
REQ-033 Asserting reset SHALL immediately force: state IDLE, counter 0, last-owner 1, all rN_gnt/rN_done/mem_en/mem_we/busy = 0, rN_rdata = 0, latched regs = 0.
REQ-034 Reset mid-transaction SHALL discard the in-flight access; no done pulse SHALL follow.
REQ-035 After reset release, SHALL resume arbitration at the first rising edge.

Verification
REQ-036 MEM_LAT=2, r0 read addr 0x100, memory returns 0xDEADBEEF -> mem_en high in cycle 1 only, r0_done in cycle 4, r0_rdata=0xDEADBEEF.
REQ-037 r0 and r1 both request from reset -> r0 granted first, r1 granted in IDLE right after r0's RESP; continuous dual requests alternate 0,1,0,1.
REQ-038 r1 write addr 0x20, be=4'b0011, wdata=0x0000ABCD -> ISSUE cycle shows mem_we=1, mem_be=0011, mem_addr=0x20, r1_done pulses 1 cycle, r1_rdata unchanged.
REQ-039 reset asserted in WAIT -> all outputs 0 the same cycle, no rN_done afterwards; r0 read after release completes normally.
REQ-040 r0 drops req in WAIT, address inputs changed -> mem_addr unchanged from latched value, r0_done still pulses.
REQ-041 MEM_LAT=1 and MEM_LAT=15 single reads -> done at cycle 3 and 17 respectively.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of one shared memory port with a
// fixed read latency; exactly one access is in flight at any time.
module mem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [3:0]    r0_be,
    input  logic [AW-1:0] r0_addr,
    input  logic [31:0]   r0_wdata,
    output logic          r0_gnt,
    output logic          r0_done,
    output logic [31:0]   r0_rdata,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [3:0]    r1_be,
    input  logic [AW-1:0] r1_addr,
    input  logic [31:0]   r1_wdata,
    output logic          r1_gnt,
    output logic          r1_done,
    output logic [31:0]   r1_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,

    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic          last_owner;
    logic          owner;
    logic          pick;
    logic          we_q;
    logic [3:0]    be_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;

    // A tie goes to whoever did not own the memory last; a lone request wins outright.
    always_comb begin
        pick = r1_req;
        if (r0_req && r1_req)
            pick = ~last_owner;
    end

    // The memory sees only the captured request, so requesters may move on once granted.
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            r0_gnt     <= 1'b0;
            r1_gnt     <= 1'b0;
            r0_done    <= 1'b0;
            r1_done    <= 1'b0;
            r0_rdata   <= 32'd0;
            r1_rdata   <= 32'd0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        owner   <= pick;
                        we_q    <= pick ? r1_we    : r0_we;
                        be_q    <= pick ? r1_be    : r0_be;
                        addr_q  <= pick ? r1_addr  : r0_addr;
                        wdata_q <= pick ? r1_wdata : r0_wdata;
                        mem_en  <= 1'b1;
                        mem_we  <= pick ? r1_we : r0_we;
                        r0_gnt  <= ~pick;
                        r1_gnt  <= pick;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    cnt    <= LAT_LOAD;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        if (!we_q) begin
                            if (owner)
                                r1_rdata <= mem_rdata;
                            else
                                r0_rdata <= mem_rdata;
                        end
                        r0_done <= ~owner;
                        r1_done <= owner;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    r0_done    <= 1'b0;
                    r1_done    <= 1'b0;
                    r0_gnt     <= 1'b0;
                    r1_gnt     <= 1'b0;
                    busy       <= 1'b0;
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (MEM_LAT 2, 1, 15), each
// backed by a small latency-accurate memory model.
module tb_mem_arbiter;

    localparam int AW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_init = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          req   [3][2];
    logic          we    [3][2];
    logic [3:0]    be    [3][2];
    logic [AW-1:0] addr  [3][2];
    logic [31:0]   wdata [3][2];
    logic          gnt   [3][2];
    logic          done  [3][2];
    logic [31:0]   rdata [3][2];
    logic          mem_en    [3];
    logic          mem_we    [3];
    logic [3:0]    mem_be    [3];
    logic [AW-1:0] mem_addr  [3];
    logic [31:0]   mem_wdata [3];
    logic [31:0]   mem_rdata [3];
    logic          busy      [3];

    typedef struct {
        int          d;
        int          w;
        int          cyc;
        logic [31:0] rdata;
        logic [31:0] other;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic        last_owner [3];
    logic [31:0] rdata_m [3][2];
    logic [31:0] mdl [256];

    function automatic logic [31:0] init_word(int i);
        return (i == 64) ? 32'hDEADBEEF : (32'h5A000000 | (32'(i) * 32'h00010203));
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        logic [31:0] mem  [256];
        logic [31:0] pipe [16];
        logic        pv   [16];

        mem_arbiter #(.MEM_LAT(LAT), .AW(AW)) dut (
            .clk(clk), .reset(reset),
            .r0_req(req[g][0]), .r0_we(we[g][0]), .r0_be(be[g][0]),
            .r0_addr(addr[g][0]), .r0_wdata(wdata[g][0]),
            .r0_gnt(gnt[g][0]), .r0_done(done[g][0]), .r0_rdata(rdata[g][0]),
            .r1_req(req[g][1]), .r1_we(we[g][1]), .r1_be(be[g][1]),
            .r1_addr(addr[g][1]), .r1_wdata(wdata[g][1]),
            .r1_gnt(gnt[g][1]), .r1_done(done[g][1]), .r1_rdata(rdata[g][1]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );

        // Read data appears exactly LAT cycles after the enable cycle, garbage otherwise.
        always @(posedge clk) begin
            pipe[0] <= mem[mem_addr[g][9:2]];
            pv[0]   <= mem_en[g] && !mem_we[g];
            for (int i = 1; i < 16; i++) begin
                pipe[i] <= pipe[i-1];
                pv[i]   <= pv[i-1];
            end
            if (mem_init) begin
                for (int i = 0; i < 256; i++)
                    mem[i] <= init_word(i);
            end else if (mem_en[g] && mem_we[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[g][b])
                        mem[mem_addr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end
        end

        assign mem_rdata[g] = pv[LAT-1] ? pipe[LAT-1] : 32'hBAD0BAD0;
    end

    task automatic checkOutput(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 2; w++) begin
                if (done[d][w] === 1'b1) begin
                    if (sb.size() == 0) begin
                        checkOutput("spurious_done", 64'(done[d][w]), 64'(0));
                    end else begin
                        mon_e = sb.pop_front();
                        checkOutput("done_dut",    64'(d), 64'(mon_e.d));
                        checkOutput("done_who",    64'(w), 64'(mon_e.w));
                        checkOutput("done_cycle",  64'(cyc), 64'(mon_e.cyc));
                        checkOutput("rdata_owner", 64'(rdata[d][w]), 64'(mon_e.rdata));
                        checkOutput("rdata_other", 64'(rdata[d][1-w]), 64'(mon_e.other));
                    end
                end
            end
        end
    end

    task automatic push_txn(int d, int w, logic wr, logic [3:0] b, logic [31:0] a,
                            logic [31:0] wd, int done_cyc);
        exp_t e;
        int   idx = int'(a[9:2]);
        if (!wr) begin
            rdata_m[d][w] = (d == 0) ? mdl[idx] : init_word(idx);
        end else if (d == 0) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) mdl[idx][8*i +: 8] = wd[8*i +: 8];
        end
        e = '{d, w, done_cyc, rdata_m[d][w], rdata_m[d][1-w]};
        sb.push_back(e);
        last_owner[d] = w[0];
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // One access from an idle arbiter; inputs are scrambled right after ISSUE.
    task automatic applyStimulus(int d, int w, logic wr, logic [3:0] b, logic [31:0] a,
                                 logic [31:0] wd, int lat);
        @(posedge clk);
        #1;
        we[d][w]    = wr;
        be[d][w]    = b;
        addr[d][w]  = a;
        wdata[d][w] = wd;
        req[d][w]   = 1'b1;
        push_txn(d, w, wr, b, a, wd, cyc + 2 + lat);
        @(posedge clk);
        #1;
        checkOutput("issue_en",        64'(mem_en[d]), 64'(1));
        checkOutput("issue_we",        64'(mem_we[d]), 64'(wr));
        checkOutput("issue_addr",      64'(mem_addr[d]), 64'(a));
        checkOutput("issue_be",        64'(mem_be[d]), 64'(b));
        checkOutput("issue_wdata",     64'(mem_wdata[d]), 64'(wd));
        checkOutput("issue_gnt",       64'(gnt[d][w]), 64'(1));
        checkOutput("issue_gnt_other", 64'(gnt[d][1-w]), 64'(0));
        checkOutput("issue_busy",      64'(busy[d]), 64'(1));
        req[d][w]   = 1'b0;
        we[d][w]    = ~wr;
        be[d][w]    = ~b;
        addr[d][w]  = ~a;
        wdata[d][w] = ~wd;
        @(posedge clk);
        #1;
        checkOutput("wait_en",   64'(mem_en[d]), 64'(0));
        checkOutput("wait_we",   64'(mem_we[d]), 64'(0));
        checkOutput("wait_addr", 64'(mem_addr[d]), 64'(a));
        checkOutput("wait_gnt",  64'(gnt[d][w]), 64'(1));
        drain(40);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   k;
        int   o;
        int   order [4];
        logic [31:0] a_of [2];

        for (int d = 0; d < 3; d++) begin
            last_owner[d] = 1'b1;
            for (int w = 0; w < 2; w++) begin
                req[d][w] = 1'b0; we[d][w] = 1'b0; be[d][w] = 4'd0;
                addr[d][w] = '0; wdata[d][w] = 32'd0; rdata_m[d][w] = 32'd0;
            end
        end
        for (int i = 0; i < 256; i++) mdl[i] = init_word(i);

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput("rst_busy",   64'(busy[d]), 64'(0));
            checkOutput("rst_mem_en", 64'(mem_en[d]), 64'(0));
            checkOutput("rst_gnt0",   64'(gnt[d][0]), 64'(0));
            checkOutput("rst_gnt1",   64'(gnt[d][1]), 64'(0));
            checkOutput("rst_rdata0", 64'(rdata[d][0]), 64'(0));
            checkOutput("rst_rdata1", 64'(rdata[d][1]), 64'(0));
        end
        reset    = 1'b0;
        mem_init = 1'b0;

        // Both requesters hold requests from reset: expect 0,1,0,1 every 5 cycles.
        @(posedge clk);
        #1;
        k = cyc;
        a_of[0] = 32'h104;
        a_of[1] = 32'h108;
        for (int w = 0; w < 2; w++) begin
            we[0][w] = 1'b0; be[0][w] = 4'hF; addr[0][w] = a_of[w]; req[0][w] = 1'b1;
        end
        for (int t = 0; t < 4; t++) begin
            o = last_owner[0] ? 0 : 1;
            order[t] = o;
            push_txn(0, o, 1'b0, 4'hF, a_of[o], 32'd0, k + 4 + 5 * t);
        end
        checkOutput("rr_first_is_r0", 64'(order[0]), 64'(0));
        for (int r = 1; r <= 16; r++) begin
            @(posedge clk);
            #1;
            checkOutput("gnt_exclusive", 64'(gnt[0][0] & gnt[0][1]), 64'(0));
            if (r % 5 == 1)
                checkOutput("rr_gnt", 64'(gnt[0][order[(r-1)/5]]), 64'(1));
        end
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
        drain(60);

        applyStimulus(0, 0, 1'b0, 4'hF,    32'h100, 32'd0,        2);
        applyStimulus(0, 1, 1'b1, 4'b0011, 32'h20,  32'h0000ABCD, 2);
        applyStimulus(0, 0, 1'b0, 4'hF,    32'h20,  32'd0,        2);
        applyStimulus(0, 0, 1'b1, 4'b1100, 32'h24,  32'h12345678, 2);
        applyStimulus(0, 0, 1'b0, 4'hF,    32'h24,  32'd0,        2);
        applyStimulus(0, 1, 1'b0, 4'hF,    32'h20,  32'd0,        2);
        applyStimulus(1, 0, 1'b0, 4'hF,    32'h100, 32'd0,        1);
        applyStimulus(2, 0, 1'b0, 4'hF,    32'h3C,  32'd0,        15);
        applyStimulus(2, 1, 1'b0, 4'hF,    32'h44,  32'd0,        15);

        // Reset during WAIT must flush the access with no done pulse later.
        @(posedge clk);
        #1;
        we[0][0] = 1'b0; be[0][0] = 4'hF; addr[0][0] = 32'h100; req[0][0] = 1'b1;
        @(posedge clk);
        #1;
        req[0][0] = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_busy",   64'(busy[0]), 64'(0));
        checkOutput("mid_rst_gnt0",   64'(gnt[0][0]), 64'(0));
        checkOutput("mid_rst_gnt1",   64'(gnt[0][1]), 64'(0));
        checkOutput("mid_rst_done0",  64'(done[0][0]), 64'(0));
        checkOutput("mid_rst_mem_en", 64'(mem_en[0]), 64'(0));
        checkOutput("mid_rst_mem_we", 64'(mem_we[0]), 64'(0));
        checkOutput("mid_rst_addr",   64'(mem_addr[0]), 64'(0));
        checkOutput("mid_rst_rdata0", 64'(rdata[0][0]), 64'(0));
        checkOutput("mid_rst_rdata1", 64'(rdata[0][1]), 64'(0));
        for (int d = 0; d < 3; d++) begin
            last_owner[d] = 1'b1;
            rdata_m[d][0] = 32'd0;
            rdata_m[d][1] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        applyStimulus(0, 0, 1'b0, 4'hF, 32'h100, 32'd0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
